// File: rtl/touch_event_detector_if.sv
// Sample/threshold/event bundle for one taxel's press/release detector.
// The producer (front end or bench) holds the master view; the detector holds the slave view.
interface touch_event_detector_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid_in;
    logic [DATA_WIDTH-1:0] press_thresh_in;
    logic [DATA_WIDTH-1:0] release_thresh_in;
    logic                  add_evt_out;
    logic                  sub_evt_out;
    logic                  pressed_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        output press_thresh_in,
        output release_thresh_in,
        input  add_evt_out,
        input  sub_evt_out,
        input  pressed_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        input  press_thresh_in,
        input  release_thresh_in,
        output add_evt_out,
        output sub_evt_out,
        output pressed_out
    );
endinterface

// File: rtl/touch_event_detector.sv
// Per-taxel press/release detector: hysteresis thresholds plus a consecutive-valid-sample
// debounce, producing registered one-cycle add/sub pulses and a debounced contact level.
module touch_event_detector #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    touch_event_detector_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_SAMPLES);
    // A single qualifying sample is enough to change state.
    localparam bit SINGLE_SAMPLE = (DEBOUNCE_SAMPLES == 1);

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'b00,
        ST_PRESS_DEB   = 2'b01,
        ST_PRESSED     = 2'b10,
        ST_RELEASE_DEB = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_cnt_done;
    logic                  r_add_evt;
    logic                  r_sub_evt;
    logic                  r_pressed;
    logic                  w_add_nxt;
    logic                  w_sub_nxt;
    logic                  w_pressed_nxt;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [DATA_WIDTH-1:0] w_press_thr;
    logic [DATA_WIDTH-1:0] w_rel_thr;
    logic                  w_valid;
    logic                  w_press_q;
    logic                  w_rel_q;

    assign w_sample    = bus.sample_in;
    assign w_press_thr = bus.press_thresh_in;
    assign w_rel_thr   = bus.release_thresh_in;
    assign w_valid     = bus.sample_valid_in;

    assign w_press_q = (w_sample >= w_press_thr);
    assign w_rel_q   = (w_sample <  w_rel_thr);

    // The run is complete when this qualifying sample brings the count to the target.
    // Written as ">=" so a corrupted count still terminates the run instead of wrapping.
    assign w_cnt_done = (r_cnt >= (CNT_FULL - CNT_ONE));
    assign w_cnt_inc  = r_cnt + CNT_ONE;

    // Next-state, run-count and pulse decode; only valid samples advance the FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_add_nxt   = 1'b0;
        w_sub_nxt   = 1'b0;
        if (w_valid) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_press_q) begin
                        if (SINGLE_SAMPLE) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = CNT_ZERO;
                            w_add_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_PRESS_DEB;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                ST_PRESS_DEB: begin
                    if (w_press_q) begin
                        if (w_cnt_done) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = CNT_ZERO;
                            w_add_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_PRESS_DEB;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                ST_PRESSED: begin
                    if (w_rel_q) begin
                        if (SINGLE_SAMPLE) begin
                            w_state_nxt = ST_RELEASED;
                            w_cnt_nxt   = CNT_ZERO;
                            w_sub_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASE_DEB;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                ST_RELEASE_DEB: begin
                    if (w_rel_q) begin
                        if (w_cnt_done) begin
                            w_state_nxt = ST_RELEASED;
                            w_cnt_nxt   = CNT_ZERO;
                            w_sub_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASE_DEB;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                default: begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
        // Contact level is held through the release debounce and dropped through the press debounce.
        w_pressed_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_DEB);
    end

    // FSM state and debounce run-length register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_RELEASED;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered event pulses and debounced level, updated on the edge of the final sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_add_evt <= 1'b0;
            r_sub_evt <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_add_evt <= w_add_nxt;
            r_sub_evt <= w_sub_nxt;
            r_pressed <= w_pressed_nxt;
        end
    end

    assign bus.add_evt_out = r_add_evt;
    assign bus.sub_evt_out = r_sub_evt;
    assign bus.pressed_out = r_pressed;

endmodule

// File: tb/tb_touch_event_detector.sv
// Bench for touch_event_detector: one instance with a 3-sample debounce and one with a
// single-sample debounce share a stimulus stream; a table of directed vectors, hand-written
// reset sequences and a randomized phase are compared against a run-length reference model.
module tb_touch_event_detector;

    logic clk;
    logic rst;

    touch_event_detector_if #(.DATA_WIDTH(8)) if3 ();
    touch_event_detector_if #(.DATA_WIDTH(8)) if1 ();

    touch_event_detector #(.DATA_WIDTH(8), .DEBOUNCE_SAMPLES(3)) dut3 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if3.slave)
    );

    touch_event_detector #(.DATA_WIDTH(8), .DEBOUNCE_SAMPLES(1)) dut1 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] prs;
    logic [7:0] rel;

    // Reference model: level plus length of the current run of valid samples
    // that qualify for the opposite level. Index 0 -> 3-sample, 1 -> 1-sample.
    int m_n   [2] = '{3, 1};
    int m_run [2];
    bit m_lvl [2];
    bit m_add [2];
    bit m_sub [2];

    typedef struct {
        bit         valid;
        logic [7:0] sample;
        bit         add;
        bit         sub;
        bit         pressed;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0;
            m_lvl[k] = 1'b0;
            m_add[k] = 1'b0;
            m_sub[k] = 1'b0;
        end
    endtask

    task automatic model_update(input bit v, input logic [7:0] s);
        bit qual;
        for (int k = 0; k < 2; k++) begin
            m_add[k] = 1'b0;
            m_sub[k] = 1'b0;
            if (v) begin
                qual = m_lvl[k] ? (s < rel) : (s >= prs);
                if (qual) m_run[k] = m_run[k] + 1;
                else      m_run[k] = 0;
                if (m_run[k] == m_n[k]) begin
                    m_run[k] = 0;
                    m_lvl[k] = ~m_lvl[k];
                    if (m_lvl[k]) m_add[k] = 1'b1;
                    else          m_sub[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] s);
        if3.sample_valid_in   = v;
        if3.sample_in         = s;
        if3.press_thresh_in   = prs;
        if3.release_thresh_in = rel;
        if1.sample_valid_in   = v;
        if1.sample_in         = s;
        if1.press_thresh_in   = prs;
        if1.release_thresh_in = rel;
    endtask

    task automatic check_model();
        check("d3_add",  if3.add_evt_out, m_add[0]);
        check("d3_sub",  if3.sub_evt_out, m_sub[0]);
        check("d3_lvl",  if3.pressed_out, m_lvl[0]);
        check("d1_add",  if1.add_evt_out, m_add[1]);
        check("d1_sub",  if1.sub_evt_out, m_sub[1]);
        check("d1_lvl",  if1.pressed_out, m_lvl[1]);
        check("d3_excl", if3.add_evt_out & if3.sub_evt_out, 1'b0);
        check("d1_excl", if1.add_evt_out & if1.sub_evt_out, 1'b0);
    endtask

    // One clock: drive a sample, let the edge take it, then compare #1 after the edge.
    task automatic step(input bit v, input logic [7:0] s);
        drive(v, s);
        @(posedge clk);
        model_update(v, s);
        #1;
        check_model();
    endtask

    function automatic void push(input bit v, input logic [7:0] s, input bit a,
                                 input bit su, input bit p, input int rep);
        vec_t e;
        e.valid = v; e.sample = s; e.add = a; e.sub = su; e.pressed = p;
        for (int i = 0; i < rep; i++) vq.push_back(e);
    endfunction

    task automatic assert_reset_midcycle(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_add3"}, if3.add_evt_out, 1'b0);
        check({tag, "_sub3"}, if3.sub_evt_out, 1'b0);
        check({tag, "_lvl3"}, if3.pressed_out, 1'b0);
        check({tag, "_lvl1"}, if1.pressed_out, 1'b0);
        drive(1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int t;
        bit rv;
        logic [7:0] rs;

        prs = 8'd100;
        rel = 8'd60;
        rst = 1'b1;
        model_reset();
        drive(1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_add3", if3.add_evt_out, 1'b0);
        check("rst_sub3", if3.sub_evt_out, 1'b0);
        check("rst_lvl3", if3.pressed_out, 1'b0);
        check("rst_add1", if1.add_evt_out, 1'b0);
        check("rst_sub1", if1.sub_evt_out, 1'b0);
        check("rst_lvl1", if1.pressed_out, 1'b0);
        rst = 1'b0;

        // Expected values for the 3-sample instance, one entry per clock.
        push(1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 10);   // idle at zero
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2);    // press run
        push(1'b1, 8'd120, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b1, 20);   // held, no re-fire
        push(1'b1, 8'd80,  1'b0, 1'b0, 1'b1, 10);   // hysteresis band
        push(1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 2);
        push(1'b1, 8'd50,  1'b0, 1'b1, 1'b0, 1);
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2);    // bounce restarts run
        push(1'b1, 8'd50,  1'b0, 1'b0, 1'b0, 1);
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2);
        push(1'b1, 8'd120, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 2);
        push(1'b1, 8'd50,  1'b0, 1'b1, 1'b0, 1);
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 1);    // gaps do not break the run
        push(1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 4);
        push(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 1);
        push(1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 2);
        push(1'b1, 8'd120, 1'b1, 1'b0, 1'b1, 1);
        push(1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1);
        push(1'b1, 8'd60,  1'b0, 1'b0, 1'b1, 5);    // equal to release level is not release
        push(1'b1, 8'd59,  1'b0, 1'b0, 1'b1, 2);
        push(1'b1, 8'd59,  1'b0, 1'b1, 1'b0, 1);
        push(1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 2);    // equal to press level is press
        push(1'b1, 8'd100, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 8'd99,  1'b0, 1'b0, 1'b1, 1);
        push(1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 2);    // bounce during release
        push(1'b1, 8'd80,  1'b0, 1'b0, 1'b1, 1);
        push(1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 2);
        push(1'b1, 8'd50,  1'b0, 1'b1, 1'b0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].valid, vq[i].sample);
            check($sformatf("tbl%0d_add", i), if3.add_evt_out, vq[i].add);
            check($sformatf("tbl%0d_sub", i), if3.sub_evt_out, vq[i].sub);
            check($sformatf("tbl%0d_lvl", i), if3.pressed_out, vq[i].pressed);
        end

        // Reset while pressed clears the level without waiting for a clock.
        repeat (3) step(1'b1, 8'd120);
        check("pre_rst_lvl3", if3.pressed_out, 1'b1);
        assert_reset_midcycle("rstp");

        // Reset discards a press debounce in progress.
        step(1'b1, 8'd120);
        step(1'b1, 8'd120);
        assert_reset_midcycle("rstd");
        step(1'b1, 8'd120);
        check("seq6_d1_add", if1.add_evt_out, 1'b1);
        check("seq6_d3_add_a", if3.add_evt_out, 1'b0);
        step(1'b1, 8'd120);
        check("seq6_d3_add_b", if3.add_evt_out, 1'b0);
        step(1'b1, 8'd120);
        check("seq6_d3_add_c", if3.add_evt_out, 1'b1);
        check("seq6_d3_lvl", if3.pressed_out, 1'b1);

        // Randomized stream with bursts of held samples and occasional threshold changes.
        hold = 0;
        rs = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                prs = 8'($urandom_range(255));
                rel = 8'($urandom_range(255));
            end else if ($urandom_range(299) == 0) begin
                prs = 8'd100;
                rel = 8'd60;
            end
            if (hold == 0) begin
                hold = int'($urandom_range(6)) + 1;
                case ($urandom_range(3))
                    0: t = int'($urandom_range(255));
                    1: t = int'(prs) + int'($urandom_range(4)) - 2;
                    2: t = int'(rel) + int'($urandom_range(4)) - 2;
                    default: t = ($urandom_range(1) == 0) ? 0 : 255;
                endcase
                if (t < 0)   t = 0;
                if (t > 255) t = 255;
                rs = 8'(t);
            end
            hold--;
            rv = ($urandom_range(9) < 7);
            step(rv, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
